cpu_reset_seq: RTL and testbench

//  Power-up / recovery reset sequencer clocked by FSBCLK from the clock generator.

---
 rtl/cpu_reset_seq.sv | 119 +++++++++++
 tb/tb_cpu_reset_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_reset_seq.sv
// cpu_reset_seq: power-up/recovery reset sequencer (lock filter, SDRAM init window, CPU reset hold)
// Ports:
//   FSBCLK       in  system clock, all state on rising edge
//   nRST_IN      in  asynchronous active-low reset
//   LOCKED       in  DCM lock (async, 2-FF synchronised)
//   CPUCLKr      in  registered CPU clock phase
//   RAMINIT_DONE in  RAM controller finished its init sequence
//   BTN_nRES     in  reset button, async active-low (only with RST_BTN_EN)
//   nCPURES      out CPU reset, active-low
//   RAMINIT_REQ  out RAM init request
//   READY        out system ready (RUN state)
//   STATE        out current state code, debug
// Optional feature: define RST_BTN_EN to add the debounced reset button.
module cpu_reset_seq #(
    parameter int LOCK_FILT   = 16,
    parameter int RAMINIT_CYC = 4096,
    parameter int CPURST_CYC  = 512,
    parameter int CNTW        = 16
`ifdef RST_BTN_EN
    ,
    parameter int DEB_CYC     = 1024
`endif
) (
    input  logic       FSBCLK,
    input  logic       nRST_IN,
    input  logic       LOCKED,
    input  logic       CPUCLKr,
    input  logic       RAMINIT_DONE,
`ifdef RST_BTN_EN
    input  logic       BTN_nRES,
`endif
    output logic       nCPURES,
    output logic       RAMINIT_REQ,
    output logic       READY,
    output logic [2:0] STATE
);
    typedef enum logic [2:0] {
        WAITLOCK = 3'd0,
        STABLE   = 3'd1,
        RAMINIT  = 3'd2,
        CPURST   = 3'd3,
        RUN      = 3'd4
    } state_t;

    state_t            state, nxt;
    logic [CNTW-1:0]   cnt, nxt_cnt, cnt_inc;
    logic              lock_q1, lock_s;
    logic              btn_press;

    assign STATE   = state;
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

`ifdef RST_BTN_EN
    localparam int DW = $clog2(DEB_CYC + 1);
    logic          btn_q1, btn_s, armed, btn_hit, btn_done;
    logic [DW-1:0] deb;
    // armed: waiting for a held-low press; disarmed: waiting for a held-high release
    assign btn_hit   = (btn_s == ~armed);
    assign btn_done  = btn_hit && (deb == DW'(DEB_CYC - 1));
    assign btn_press = armed && btn_done;
    always_ff @(posedge FSBCLK or negedge nRST_IN) begin
        if (!nRST_IN) begin
            btn_q1 <= 1'b0;
            btn_s  <= 1'b0;
            armed  <= 1'b1;
            deb    <= '0;
        end else begin
            btn_q1 <= BTN_nRES;
            btn_s  <= btn_q1;
            deb    <= (!btn_hit || btn_done) ? '0 : deb + 1'b1;
            armed  <= btn_done ? ~armed : armed;
        end
    end
`else
    assign btn_press = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        nxt_cnt = '0;
        if (state != WAITLOCK && !lock_s)
            nxt = WAITLOCK;
        else
            case (state)
                WAITLOCK: nxt = lock_s ? STABLE : WAITLOCK;
                STABLE:   if (cnt == CNTW'(LOCK_FILT - 1)) nxt = RAMINIT;
                          else nxt_cnt = cnt_inc;
                // RAMINIT_DONE only counts once the minimum window has elapsed
                RAMINIT:  if (cnt >= CNTW'(RAMINIT_CYC - 1) && RAMINIT_DONE) nxt = CPURST;
                          else nxt_cnt = (cnt >= CNTW'(RAMINIT_CYC)) ? cnt : cnt_inc;
                // one count per CPU period; release only on a CPUCLKr=1 cycle
                CPURST:   if (btn_press) nxt_cnt = '0;
                          else if (CPUCLKr && cnt == CNTW'(CPURST_CYC - 1)) nxt = RUN;
                          else nxt_cnt = CPUCLKr ? cnt_inc : cnt;
                RUN:      nxt = btn_press ? CPURST : RUN;
                default:  nxt = WAITLOCK;
            endcase
    end

    always_ff @(posedge FSBCLK or negedge nRST_IN) begin
        if (!nRST_IN) begin
            lock_q1     <= 1'b0;
            lock_s      <= 1'b0;
            state       <= WAITLOCK;
            cnt         <= '0;
            nCPURES     <= 1'b0;
            RAMINIT_REQ <= 1'b0;
            READY       <= 1'b0;
        end else begin
            lock_q1     <= LOCKED;
            lock_s      <= lock_q1;
            state       <= nxt;
            cnt         <= nxt_cnt;
            nCPURES     <= (nxt == RUN);
            RAMINIT_REQ <= (nxt == RAMINIT);
            READY       <= (nxt == RUN);
        end
    end
endmodule

// File: tb/tb_cpu_reset_seq.sv
// tb_cpu_reset_seq: directed table and sequence checks for cpu_reset_seq
module tb_cpu_reset_seq;
    logic       FSBCLK = 1'b0;
    logic       nRST_IN = 1'b0;
    logic       LOCKED = 1'b0;
    logic       CPUCLKr = 1'b0;
    logic       RAMINIT_DONE = 1'b0;
`ifdef RST_BTN_EN
    logic       BTN_nRES = 1'b1;
`endif
    logic       nCPURES, RAMINIT_REQ, READY;
    logic [2:0] STATE;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        logic       lk;
        logic       cpu;
        logic       done;
        logic [2:0] st;
        logic       n;
        logic       req;
        logic       rdy;
    } vec_t;
    vec_t tbl[$];

    cpu_reset_seq #(
        .LOCK_FILT(4), .RAMINIT_CYC(8), .CPURST_CYC(4), .CNTW(8)
`ifdef RST_BTN_EN
        , .DEB_CYC(4)
`endif
    ) dut (
        .FSBCLK(FSBCLK),
        .nRST_IN(nRST_IN),
        .LOCKED(LOCKED),
        .CPUCLKr(CPUCLKr),
        .RAMINIT_DONE(RAMINIT_DONE),
`ifdef RST_BTN_EN
        .BTN_nRES(BTN_nRES),
`endif
        .nCPURES(nCPURES),
        .RAMINIT_REQ(RAMINIT_REQ),
        .READY(READY),
        .STATE(STATE)
    );

    always #5 FSBCLK = ~FSBCLK;

    task automatic tick();
        @(posedge FSBCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] st, input logic n, input logic req, input logic rdy);
        checks++;
        if ({STATE, nCPURES, RAMINIT_REQ, READY} !== {st, n, req, rdy}) begin
            failures++;
            $display("FAIL %s: got state=%0d ncpures=%b req=%b ready=%b, want state=%0d ncpures=%b req=%b ready=%b",
                     name, STATE, nCPURES, RAMINIT_REQ, READY, st, n, req, rdy);
        end
    endtask

    task automatic step(input logic lk, input logic cpu, input logic done, input string name,
                        input logic [2:0] st, input logic n, input logic req, input logic rdy);
        LOCKED = lk;
        CPUCLKr = cpu;
        RAMINIT_DONE = done;
        tick();
        chk(name, st, n, req, rdy);
    endtask

    task automatic add(input logic lk, input logic cpu, input logic done,
                       input logic [2:0] st, input logic n, input logic req, input logic rdy);
        tbl.push_back('{lk, cpu, done, st, n, req, rdy});
    endtask

    task automatic do_reset(input logic lk, input logic done);
        nRST_IN = 1'b0;
        LOCKED = lk;
        RAMINIT_DONE = done;
        CPUCLKr = 1'b0;
        tick();
        chk("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        nRST_IN = 1'b1;
    endtask

    task automatic go_cpurst();
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            CPUCLKr = 1'b0;
            tick();
        end
        chk("reach_cpurst", 3'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go_run();
        go_cpurst();
        for (int i = 0; i < 7; i++) begin
            CPUCLKr = (i % 2 == 0);
            tick();
        end
        chk("reach_run", 3'd4, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        // 1: full power-up sequence, one table row per clock edge
        for (int i = 0; i < 2; i++) add(1, 0, 1, 3'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 1, 3'd1, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 0, 1, 3'd2, 0, 1, 0);
        add(1, 0, 1, 3'd3, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(1, (i % 2 == 0), 1, 3'd3, 0, 0, 0);
        add(1, 1, 1, 3'd4, 1, 0, 1);
        add(1, 0, 1, 3'd4, 1, 0, 1);
        do_reset(1'b1, 1'b1);
        foreach (tbl[i])
            step(tbl[i].lk, tbl[i].cpu, tbl[i].done, $sformatf("t1_row%0d", i),
                 tbl[i].st, tbl[i].n, tbl[i].req, tbl[i].rdy);

        // 2: early RAMINIT_DONE pulse ignored, later one honoured
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, "t2_enter", (i < 2) ? 3'd0 : (i < 6) ? 3'd1 : 3'd2, 0, (i == 6), 0);
        for (int k = 0; k <= 12; k++)
            step(1, 0, (k == 3 || k == 12), $sformatf("t2_cyc%0d", k),
                 (k < 12) ? 3'd2 : 3'd3, 0, (k < 12), 0);

        // 3: one-cycle lock glitch in STABLE restarts the filter
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1, 0, 1, "t3_enter", (i < 2) ? 3'd0 : 3'd1, 0, 0, 0);
        step(0, 0, 1, "t3_glitch_a", 3'd1, 0, 0, 0);
        step(1, 0, 1, "t3_glitch_b", 3'd1, 0, 0, 0);
        step(1, 0, 1, "t3_lost", 3'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, "t3_refilter", 3'd1, 0, 0, 0);
        step(1, 0, 1, "t3_raminit", 3'd2, 0, 1, 0);

        // 4: loss of lock in RUN, then full re-sequence
        go_run();
        step(0, 0, 1, "t4_sync1", 3'd4, 1, 0, 1);
        step(0, 0, 1, "t4_sync2", 3'd4, 1, 0, 1);
        step(0, 0, 1, "t4_drop", 3'd0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 1, "t4_relock", 3'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, "t4_stable", 3'd1, 0, 0, 0);
        step(1, 0, 1, "t4_raminit", 3'd2, 0, 1, 0);

`ifdef RST_BTN_EN
        // 5: short press filtered, long press restarts CPU reset once
        go_run();
        BTN_nRES = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 0, 1, "t5_short", 3'd4, 1, 0, 1);
        BTN_nRES = 1'b1;
        for (int i = 0; i < 6; i++) step(1, 0, 1, "t5_short_after", 3'd4, 1, 0, 1);
        BTN_nRES = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 0, 1, "t5_deb", 3'd4, 1, 0, 1);
        step(1, 0, 1, "t5_press", 3'd3, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, (i % 2 == 0), 1, "t5_hold", 3'd3, 0, 0, 0);
        step(1, 1, 1, "t5_release", 3'd4, 1, 0, 1);
        for (int i = 0; i < 10; i++) step(1, (i % 2 == 0), 1, "t5_held_once", 3'd4, 1, 0, 1);
        BTN_nRES = 1'b1;
        for (int i = 0; i < 6; i++) step(1, 0, 1, "t5_up", 3'd4, 1, 0, 1);
`endif

        // 6: asynchronous reset between edges while in CPURST
        go_cpurst();
        #3 nRST_IN = 1'b0;
        #1 chk("t6_async", 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t6_held", 3'd0, 1'b0, 1'b0, 1'b0);
        nRST_IN = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
